operand_stack: RTL and testbench

Hardware operand stack feeding the single-cycle ALU of the stack machine. It presents top-of-stack (TOS) and next-of-stack (NOS) as `operand1`/`operand2`, selects stack or immediate via `alu_src`, and writes `alu_result` back in the same cycle it is consumed. It also tracks depth, and traps underflow and overflow with a sticky error that stalls the command handshake until cleared.

---
 rtl/stack_pkg.sv | 40 ++++
 rtl/operand_stack_if.sv | 42 ++++
 rtl/stack_regfile.sv | 34 +++
 rtl/operand_stack.sv | 207 ++++++++++++++++++++
 tb/tb_operand_stack.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/stack_pkg.sv
// Shared types for the operand stack: command encodings, trap codes, FSM states.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package stack_pkg;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'b000,
    CMD_PUSH = 3'b001,
    CMD_POP  = 3'b010,
    CMD_BIN  = 3'b011,
    CMD_UNI  = 3'b100,
    CMD_IMM  = 3'b101,
    CMD_DUP  = 3'b110,
    CMD_SWAP = 3'b111
  } stack_cmd_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_OVER  = 2'b10;

  typedef enum logic {
    RUN   = 1'b0,
    ERROR = 1'b1
  } stack_state_t;

  // Number of live entries a command must find on the stack.
  function automatic logic [1:0] min_entries(stack_cmd_t c);
    case (c)
      CMD_BIN, CMD_SWAP:                   min_entries = 2'd2;
      CMD_POP, CMD_UNI, CMD_IMM, CMD_DUP:  min_entries = 2'd1;
      default:                             min_entries = 2'd0;
    endcase
  endfunction

  // Commands that add one entry and therefore cannot run on a full stack.
  function automatic logic grows(stack_cmd_t c);
    grows = (c == CMD_PUSH) || (c == CMD_DUP);
  endfunction

endpackage

// File: rtl/operand_stack_if.sv
// Command / ALU / status bundle between the stack machine controller and the operand stack.
// Latency: wires only.
// Backpressure: cmd_ready from the stack gates cmd_valid from the controller.
// Ports: master = controller+ALU side (drives cmd, imm, err_clear, alu_result);
//        slave  = operand stack (drives cmd_ready, operands, tos/count/flags, error).
interface operand_stack_if #(
  parameter int REG_BITS = 32,
  parameter int DEPTH    = 16
);
  import stack_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic                cmd_valid;
  logic                cmd_ready;
  stack_cmd_t          cmd;
  logic [REG_BITS-1:0] imm;
  logic                err_clear;
  logic [REG_BITS-1:0] operand1;
  logic [REG_BITS-1:0] operand2;
  logic                alu_src;
  logic [REG_BITS-1:0] alu_result;
  logic [REG_BITS-1:0] tos;
  logic [CW-1:0]       count;
  logic                empty;
  logic                full;
  logic                error;
  logic [1:0]          err_code;

  modport master (
    output cmd_valid, cmd, imm, err_clear, alu_result,
    input  cmd_ready, operand1, operand2, alu_src,
    input  tos, count, empty, full, error, err_code
  );

  modport slave (
    input  cmd_valid, cmd, imm, err_clear, alu_result,
    output cmd_ready, operand1, operand2, alu_src,
    output tos, count, empty, full, error, err_code
  );

endinterface

// File: rtl/stack_regfile.sv
// Stack storage: DEPTH x REG_BITS array, two async read ports, two sync write ports.
// Latency: reads combinational, writes visible after the rising edge.
// Backpressure: none; caller guarantees the two write addresses differ when both fire.
// Ports: clk; rd0/rd1 address->data; we0/wa0/wd0 main write; we1/wa1/wd1 second write (SWAP only).
module stack_regfile #(
  parameter int REG_BITS = 32,
  parameter int DEPTH    = 16,
  parameter int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic [AW-1:0]       rd0_addr,
  output logic [REG_BITS-1:0] rd0_data,
  input  logic [AW-1:0]       rd1_addr,
  output logic [REG_BITS-1:0] rd1_data,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [REG_BITS-1:0] wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [REG_BITS-1:0] wd1
);

  // Contents are deliberately not reset; the count register decides what is live.
  logic [REG_BITS-1:0] mem [DEPTH];

  assign rd0_data = mem[rd0_addr];
  assign rd1_data = mem[rd1_addr];

  always_ff @(posedge clk) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
  end

endmodule

// File: rtl/operand_stack.sv
// Operand stack for the single-cycle ALU: presents TOS/NOS operands, writes alu_result back, traps under/overflow.
// Latency: operands combinational from cmd; tos/count/flags update one edge after acceptance.
// Backpressure: cmd_ready=1 in RUN (one command per cycle); 0 in ERROR until err_clear.
// Ports: clk, reset (sync, active-high); bus = operand_stack_if.slave (command, ALU and status signals).
module operand_stack
  import stack_pkg::*;
#(
  parameter int REG_BITS = 32,
  parameter int DEPTH    = 16
) (
  input  logic           clk,
  input  logic           reset,
  operand_stack_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] TWO      = CW'(2);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [CW-1:0]       count_q, count_d;
  stack_state_t        state_q, state_d;
  logic [1:0]          err_code_q, err_code_d;

  logic                has1, has2, is_full;
  logic [AW-1:0]       tos_addr, nos_addr, push_addr;
  logic [REG_BITS-1:0] tos_raw, nos_raw, tos_val, nos_val;

  logic                accept, under, over, trap, exec;

  logic                we0, we1;
  logic [AW-1:0]       wa0, wa1;
  logic [REG_BITS-1:0] wd0, wd1;

  // ---------------------------------------------------------------------------
  // Addressing: the stack grows upward from entry 0, TOS lives at count-1.
  // Addresses are clamped to 0 when the slot does not exist so the array is
  // never indexed out of range; the value is then masked to 0 below.
  // ---------------------------------------------------------------------------
  assign has1    = (count_q >= ONE);
  assign has2    = (count_q >= TWO);
  assign is_full = (count_q == FULL_CNT);

  assign tos_addr  = has1 ? AW'(count_q - ONE) : '0;
  assign nos_addr  = has2 ? AW'(count_q - TWO) : '0;
  assign push_addr = is_full ? '0 : AW'(count_q);

  stack_regfile #(
    .REG_BITS (REG_BITS),
    .DEPTH    (DEPTH),
    .AW       (AW)
  ) u_regfile (
    .clk      (clk),
    .rd0_addr (tos_addr),
    .rd0_data (tos_raw),
    .rd1_addr (nos_addr),
    .rd1_data (nos_raw),
    .we0      (we0 & ~reset),
    .wa0      (wa0),
    .wd0      (wd0),
    .we1      (we1 & ~reset),
    .wa1      (wa1),
    .wd1      (wd1)
  );

  assign tos_val = has1 ? tos_raw : '0;
  assign nos_val = has2 ? nos_raw : '0;

  // ---------------------------------------------------------------------------
  // Handshake and trap detection. A trapping command is accepted (it consumes
  // the handshake) but has no effect on storage or count.
  // ---------------------------------------------------------------------------
  assign bus.cmd_ready = (state_q == RUN);
  assign accept        = bus.cmd_valid & bus.cmd_ready;
  assign under         = (count_q < CW'(min_entries(bus.cmd)));
  assign over          = grows(bus.cmd) & is_full;
  assign trap          = accept & (under | over);
  assign exec          = accept & ~(under | over);

  // ---------------------------------------------------------------------------
  // Command execution: write-port controls and next count.
  // ---------------------------------------------------------------------------
  always_comb begin
    we0     = 1'b0;
    wa0     = tos_addr;
    wd0     = '0;
    we1     = 1'b0;
    wa1     = nos_addr;
    wd1     = '0;
    count_d = count_q;
    if (exec) begin
      case (bus.cmd)
        CMD_PUSH: begin
          we0     = 1'b1;
          wa0     = push_addr;
          wd0     = bus.imm;
          count_d = count_q + ONE;
        end
        CMD_POP: begin
          count_d = count_q - ONE;
        end
        CMD_BIN: begin
          // Both operands are consumed; the result lands where NOS was.
          we0     = 1'b1;
          wa0     = nos_addr;
          wd0     = bus.alu_result;
          count_d = count_q - ONE;
        end
        CMD_UNI, CMD_IMM: begin
          we0 = 1'b1;
          wa0 = tos_addr;
          wd0 = bus.alu_result;
        end
        CMD_DUP: begin
          we0     = 1'b1;
          wa0     = push_addr;
          wd0     = tos_val;
          count_d = count_q + ONE;
        end
        CMD_SWAP: begin
          we0 = 1'b1;
          wa0 = tos_addr;
          wd0 = nos_val;
          we1 = 1'b1;
          wa1 = nos_addr;
          wd1 = tos_val;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Error FSM: RUN accepts commands; ERROR holds off the handshake until the
  // controller acknowledges with err_clear.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    case (state_q)
      RUN: begin
        if (trap) begin
          state_d    = ERROR;
          err_code_d = under ? ERR_UNDER : ERR_OVER;
        end
      end
      ERROR: begin
        if (bus.err_clear) begin
          state_d    = RUN;
          err_code_d = ERR_NONE;
        end
      end
      default: begin
        state_d    = RUN;
        err_code_d = ERR_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      state_q    <= RUN;
      err_code_q <= ERR_NONE;
    end else begin
      count_q    <= count_d;
      state_q    <= state_d;
      err_code_q <= err_code_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand mux: purely a function of current stack contents and cmd, so the
  // ALU result is ready to be written back at the same edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.operand1 = '0;
    bus.operand2 = '0;
    bus.alu_src  = 1'b0;
    case (bus.cmd)
      CMD_BIN: begin
        bus.operand1 = nos_val;
        bus.operand2 = tos_val;
      end
      CMD_UNI: begin
        bus.operand1 = tos_val;
      end
      CMD_IMM: begin
        bus.operand1 = tos_val;
        bus.operand2 = bus.imm;
        bus.alu_src  = 1'b1;
      end
      default: ;
    endcase
  end

  // Status outputs.
  assign bus.tos      = tos_val;
  assign bus.count    = count_q;
  assign bus.empty    = (count_q == '0);
  assign bus.full     = is_full;
  assign bus.error    = (state_q == ERROR);
  assign bus.err_code = err_code_q;

endmodule

// File: tb/tb_operand_stack.sv
module tb_operand_stack;
  import stack_pkg::*;

  localparam int RB = 32;
  localparam int DP = 4;

  typedef enum int {F_OP1, F_OP2, F_SRC, F_TOS, F_COUNT, F_EMPTY, F_FULL, F_ERR, F_CODE, F_RDY} fld_t;

  typedef struct {
    int          cyc;
    fld_t        f;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  operand_stack_if #(.REG_BITS(RB), .DEPTH(DP)) bus();

  operand_stack #(.REG_BITS(RB), .DEPTH(DP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference ALU: 0 add, 1 sub, 2 bitwise-not of operand1.
  logic [1:0] alu_op = 2'd0;
  always_comb begin
    case (alu_op)
      2'd1:    bus.alu_result = bus.operand1 - bus.operand2;
      2'd2:    bus.alu_result = ~bus.operand1;
      default: bus.alu_result = bus.operand1 + bus.operand2;
    endcase
  end

  int    cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t  q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  string cur_name    = "";

  function automatic logic [31:0] sample(fld_t f);
    case (f)
      F_OP1:   return bus.operand1;
      F_OP2:   return bus.operand2;
      F_SRC:   return 32'(bus.alu_src);
      F_TOS:   return bus.tos;
      F_COUNT: return 32'(bus.count);
      F_EMPTY: return 32'(bus.empty);
      F_FULL:  return 32'(bus.full);
      F_ERR:   return 32'(bus.error);
      F_CODE:  return 32'(bus.err_code);
      default: return 32'(bus.cmd_ready);
    endcase
  endfunction

  // Monitor: at every falling edge, retire all expectations due this cycle.
  exp_t        e;
  logic [31:0] act;
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e   = q.pop_front();
        act = sample(e.f);
        vectors++;
        if (e.cyc != cyc || act !== e.val) begin
          miscompares++;
          $display("FAIL %s/%s: got %h want %h (cycle %0d due %0d)",
                   e.name, e.f.name(), act, e.val, cyc, e.cyc);
        end
      end
    end
  end

  // Drive one cycle of stimulus, just after the rising edge.
  task automatic issue(input string nm, input stack_cmd_t c, input logic [31:0] im,
                       input bit v, input bit clr, input bit rst, input logic [1:0] aop);
    @(posedge clk);
    #2;
    cur_name      = nm;
    reset         = rst;
    bus.cmd       = c;
    bus.imm       = im;
    bus.cmd_valid = v;
    bus.err_clear = clr;
    alu_op        = aop;
  endtask

  // Expected combinational operand outputs in the cycle just issued.
  task automatic exp_ops(input logic [31:0] o1, input logic [31:0] o2, input bit src);
    q.push_back('{cyc, F_OP1, o1, cur_name});
    q.push_back('{cyc, F_OP2, o2, cur_name});
    q.push_back('{cyc, F_SRC, 32'(src), cur_name});
  endtask

  // Expected registered state after the edge that ends the cycle just issued.
  task automatic exp_state(input logic [31:0] t, input int cnt, input bit emp, input bit ful,
                           input bit er, input logic [1:0] code, input bit rdy);
    q.push_back('{cyc + 1, F_TOS,   t,           cur_name});
    q.push_back('{cyc + 1, F_COUNT, 32'(cnt),    cur_name});
    q.push_back('{cyc + 1, F_EMPTY, 32'(emp),    cur_name});
    q.push_back('{cyc + 1, F_FULL,  32'(ful),    cur_name});
    q.push_back('{cyc + 1, F_ERR,   32'(er),     cur_name});
    q.push_back('{cyc + 1, F_CODE,  32'(code),   cur_name});
    q.push_back('{cyc + 1, F_RDY,   32'(rdy),    cur_name});
  endtask

  initial begin
    bus.cmd       = CMD_NOP;
    bus.imm       = '0;
    bus.cmd_valid = 1'b0;
    bus.err_clear = 1'b0;

    // Reset state.
    issue("reset",      CMD_NOP,  0, 0, 0, 1, 0); exp_ops(0, 0, 0); exp_state(0, 0, 1, 0, 0, 0, 1);

    // Push 2, push 1, BIN add -> 3.
    issue("push2",      CMD_PUSH, 2, 1, 0, 0, 0); exp_state(2, 1, 0, 0, 0, 0, 1);
    issue("push1",      CMD_PUSH, 1, 1, 0, 0, 0); exp_state(1, 2, 0, 0, 0, 0, 1);
    issue("bin_add",    CMD_BIN,  0, 1, 0, 0, 0); exp_ops(2, 1, 0); exp_state(3, 1, 0, 0, 0, 0, 1);
    issue("pop",        CMD_POP,  0, 1, 0, 0, 0); exp_state(0, 0, 1, 0, 0, 0, 1);

    // Push 1, push 2, BIN sub -> 1-2.
    issue("push1b",     CMD_PUSH, 1, 1, 0, 0, 0); exp_state(1, 1, 0, 0, 0, 0, 1);
    issue("push2b",     CMD_PUSH, 2, 1, 0, 0, 0); exp_state(2, 2, 0, 0, 0, 0, 1);
    issue("bin_sub",    CMD_BIN,  0, 1, 0, 0, 1); exp_ops(1, 2, 0); exp_state(32'hFFFF_FFFF, 1, 0, 0, 0, 0, 1);
    issue("pop_b",      CMD_POP,  0, 1, 0, 0, 0); exp_state(0, 0, 1, 0, 0, 0, 1);

    // Push 2, IMM 3 add -> 5; UNI not -> ~5; err_clear in RUN is a no-op.
    issue("push2c",     CMD_PUSH, 2, 1, 0, 0, 0); exp_state(2, 1, 0, 0, 0, 0, 1);
    issue("imm_add",    CMD_IMM,  3, 1, 0, 0, 0); exp_ops(2, 3, 1); exp_state(5, 1, 0, 0, 0, 0, 1);
    issue("uni_not",    CMD_UNI,  9, 1, 0, 0, 2); exp_ops(5, 0, 0); exp_state(32'hFFFF_FFFA, 1, 0, 0, 0, 0, 1);
    issue("clr_in_run", CMD_NOP,  0, 1, 1, 0, 0); exp_state(32'hFFFF_FFFA, 1, 0, 0, 0, 0, 1);
    issue("pop_c",      CMD_POP,  0, 1, 0, 0, 0); exp_state(0, 0, 1, 0, 0, 0, 1);

    // Underflow trap, stalled handshake, clear cycle accepts nothing.
    issue("reset2",     CMD_NOP,  0, 0, 0, 1, 0); exp_state(0, 0, 1, 0, 0, 0, 1);
    issue("bin_under",  CMD_BIN,  0, 1, 0, 0, 0); exp_ops(0, 0, 0); exp_state(0, 0, 1, 0, 1, 1, 0);
    issue("push_in_err",CMD_PUSH, 7, 1, 0, 0, 0); exp_state(0, 0, 1, 0, 1, 1, 0);
    issue("clr_push9",  CMD_PUSH, 9, 1, 1, 0, 0); exp_state(0, 0, 1, 0, 0, 0, 1);
    issue("push7",      CMD_PUSH, 7, 1, 0, 0, 0); exp_state(7, 1, 0, 0, 0, 0, 1);

    // DUP on an empty stack underflows.
    issue("reset3",     CMD_NOP,  0, 0, 0, 1, 0); exp_state(0, 0, 1, 0, 0, 0, 1);
    issue("dup_under",  CMD_DUP,  0, 1, 0, 0, 0); exp_state(0, 0, 1, 0, 1, 1, 0);
    issue("clr_dup",    CMD_NOP,  0, 0, 1, 0, 0); exp_state(0, 0, 1, 0, 0, 0, 1);

    // Fill DEPTH=4, fifth push overflows.
    for (int k = 1; k <= 4; k++) begin
      issue("fill",     CMD_PUSH, 32'(k), 1, 0, 0, 0); exp_state(32'(k), k, 0, (k == 4), 0, 0, 1);
    end
    issue("push_over",  CMD_PUSH, 5, 1, 0, 0, 0); exp_state(4, 4, 0, 1, 1, 2, 0);
    issue("clr_over",   CMD_NOP,  0, 0, 1, 0, 0); exp_state(4, 4, 0, 1, 0, 0, 1);

    // SWAP, peek NOS via BIN operands without valid, DUP, reset with a PUSH.
    issue("reset4",     CMD_NOP,  0, 0, 0, 1, 0); exp_state(0, 0, 1, 0, 0, 0, 1);
    issue("push7b",     CMD_PUSH, 7, 1, 0, 0, 0); exp_state(7, 1, 0, 0, 0, 0, 1);
    issue("push9",      CMD_PUSH, 9, 1, 0, 0, 0); exp_state(9, 2, 0, 0, 0, 0, 1);
    issue("swap",       CMD_SWAP, 0, 1, 0, 0, 0); exp_ops(0, 0, 0); exp_state(7, 2, 0, 0, 0, 0, 1);
    issue("peek_nos",   CMD_BIN,  0, 0, 0, 0, 0); exp_ops(9, 7, 0); exp_state(7, 2, 0, 0, 0, 0, 1);
    issue("dup",        CMD_DUP,  0, 1, 0, 0, 0); exp_state(7, 3, 0, 0, 0, 0, 1);
    issue("rst_push5",  CMD_PUSH, 5, 1, 0, 1, 0); exp_state(0, 0, 1, 0, 0, 0, 1);

    // Drain the scoreboard.
    issue("idle",       CMD_NOP,  0, 0, 0, 0, 0);
    issue("idle",       CMD_NOP,  0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
